// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int NUM_PORTS = 2;

    // last_grant = 1 makes port 0 win the first tie after reset
    localparam logic RST_LAST_GRANT = 1'b1;
    localparam logic RST_ACK        = 1'b0;
    localparam logic RST_WE         = 1'b0;
    localparam logic RST_WINNER     = 1'b0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request ports and memory bus of the arbiter. "master" is the system side
// (requesters plus the memory itself), "slave" is the arbiter.
interface mem_arbiter_if #(
    parameter int WIDTH_ADDR = 16,
    parameter int WIDTH      = 8
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [WIDTH_ADDR-1:0] addr0;
    logic [WIDTH_ADDR-1:0] addr1;
    logic [WIDTH-1:0]      wdata0;
    logic [WIDTH-1:0]      wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [WIDTH-1:0]      rdata0;
    logic [WIDTH-1:0]      rdata1;
    logic [WIDTH_ADDR-1:0] mem_addr;
    logic                  mem_bus_dir;
    logic                  mem_load_main;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, mem_addr, mem_bus_dir,
               mem_load_main, mem_wdata, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, mem_addr, mem_bus_dir,
               mem_load_main, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the port
// that was not granted last. Output is only meaningful when some req is high.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 last_grant,
    output logic                 grant
);

    // Combinational grant index
    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one access per three cycles, round-robin on ties.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | sampling req0/req1; winner's command latched on exit
//   ACCESS | latched command driven to memory; write strobe if we_q
//   DONE   | ack pulse to winner; read data already captured
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH_ADDR = 16,
    parameter int WIDTH      = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_e                state_q, state_d;
    logic                  winner_q, winner_d;
    logic                  we_q, we_d;
    logic                  last_grant_q, last_grant_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [WIDTH_ADDR-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata0_q, rdata0_d;
    logic [WIDTH-1:0]      rdata1_q, rdata1_d;
    logic                  grant;
    logic                  in_access;

    rr_arbiter2 u_rr (
        .req        ({bus.req1, bus.req0}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        we_d         = we_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d      = ACCESS;
                    winner_d     = grant;
                    last_grant_d = grant;
                    we_d         = grant ? bus.we1    : bus.we0;
                    addr_d       = grant ? bus.addr1  : bus.addr0;
                    wdata_d      = grant ? bus.wdata1 : bus.wdata0;
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (winner_q) begin
                    ack1_d = 1'b1;
                end else begin
                    ack0_d = 1'b1;
                end
                if (!we_q) begin
                    if (winner_q) begin
                        rdata1_d = bus.mem_rdata;
                    end else begin
                        rdata0_d = bus.mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            winner_q     <= RST_WINNER;
            we_q         <= RST_WE;
            last_grant_q <= RST_LAST_GRANT;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ack0_q       <= RST_ACK;
            ack1_q       <= RST_ACK;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
        end
    end

    // The strobe is decoded from state so a reset edge during ACCESS still
    // commits the write already presented to memory.
    assign in_access         = (state_q == ACCESS);
    assign bus.mem_load_main = in_access && we_q;
    assign bus.mem_bus_dir   = ~(in_access && we_q);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.ack0          = ack0_q;
    assign bus.ack1          = ack1_q;
    assign bus.rdata0        = rdata0_q;
    assign bus.rdata1        = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural asynchronous-read memory.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst;

    mem_arbiter_if #(.WIDTH_ADDR(16), .WIDTH(8)) bus ();

    mem_arbiter #(.WIDTH_ADDR(16), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;
    int          wr_cnt;
    int          ack0_cnt;
    int          ack1_cnt;
    int          n_checks;
    int          n_fail;

    assign bus.mem_rdata = mem[bus.mem_addr];

    // Memory write port: bench preload or DUT strobe
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.mem_load_main) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Count ack pulses
    always @(negedge clk) begin
        if (bus.ack0) ack0_cnt <= ack0_cnt + 1;
        if (bus.ack1) ack1_cnt <= ack1_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ack0"},  bus.ack0, 0);
        check_eq({tag, "_ack1"},  bus.ack1, 0);
        check_eq({tag, "_rd0"},   bus.rdata0, 0);
        check_eq({tag, "_rd1"},   bus.rdata1, 0);
        check_eq({tag, "_maddr"}, bus.mem_addr, 0);
        check_eq({tag, "_mwd"},   bus.mem_wdata, 0);
        check_eq({tag, "_busy"},  bus.busy, 0);
        check_eq({tag, "_dir"},   bus.mem_bus_dir, 1);
        check_eq({tag, "_load"},  bus.mem_load_main, 0);
    endtask

    // One request from one port, checked cycle by cycle: ACCESS, DONE, IDLE
    task automatic do_access(input logic port, input logic we, input logic [15:0] a,
                             input logic [7:0] wd, input logic [7:0] exp_rd);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
        end
        tick();
        check_eq("acc_busy", bus.busy, 1);
        check_eq("acc_addr", bus.mem_addr, a);
        check_eq("acc_load", bus.mem_load_main, we);
        check_eq("acc_dir",  bus.mem_bus_dir, !we);
        if (we) check_eq("acc_wdata", bus.mem_wdata, wd);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        check_eq("acc_ack0", bus.ack0, !port);
        check_eq("acc_ack1", bus.ack1, port);
        check_eq("done_load", bus.mem_load_main, 0);
        check_eq("done_dir",  bus.mem_bus_dir, 1);
        if (we) check_eq("acc_mem", mem[a], wd);
        else    check_eq("acc_rdata", port ? bus.rdata1 : bus.rdata0, exp_rd);
        tick();
        check_eq("idle_ack0", bus.ack0, 0);
        check_eq("idle_ack1", bus.ack1, 0);
        check_eq("idle_busy", bus.busy, 0);
    endtask

    int wr0, a0, a1;

    initial begin
        n_checks = 0; n_fail = 0;
        wr_cnt = 0; ack0_cnt = 0; ack1_cnt = 0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 1'b0;

        preload(16'h0100, 8'h11);
        preload(16'h0200, 8'h22);
        preload(16'h0010, 8'h55);
        preload(16'h0020, 8'h66);
        preload(16'hFFFF, 8'h3C);

        // Simultaneous held requests: grants 0,1,0,1, one ack every 3 cycles
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0100;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("tie_busy", bus.busy, 1);
            check_eq("tie_addr", bus.mem_addr, (k % 2 == 0) ? 16'h0100 : 16'h0200);
            tick();
            check_eq("tie_ack0", bus.ack0, (k % 2 == 0));
            check_eq("tie_ack1", bus.ack1, (k % 2 == 1));
            check_eq("tie_rdata", (k % 2 == 0) ? bus.rdata0 : bus.rdata1,
                     (k % 2 == 0) ? 8'h11 : 8'h22);
            tick();
            check_eq("tie_gap0", bus.ack0, 0);
            check_eq("tie_gap1", bus.ack1, 0);
            check_eq("tie_idle", bus.busy, 0);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();

        // Address change after latching is ignored
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
        tick();
        check_eq("late_addr_acc", bus.mem_addr, 16'h0010);
        bus.addr0 = 16'h0020;
        bus.req0  = 1'b0;
        tick();
        check_eq("late_addr_done", bus.mem_addr, 16'h0010);
        check_eq("late_ack0", bus.ack0, 1);
        check_eq("late_rdata0", bus.rdata0, 8'h55);
        tick();

        // Port 1 reads top address; port 0 result untouched
        do_access(1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h3C);
        check_eq("p1_rd0_kept", bus.rdata0, 8'h55);

        // Write via port 0, read back via port 1; one strobe total
        wr0 = wr_cnt;
        do_access(1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00);
        check_eq("wr_once", wr_cnt - wr0, 1);
        do_access(1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5);
        check_eq("wr_once_after_rd", wr_cnt - wr0, 1);
        check_eq("rd1_kept", bus.rdata1, 8'hA5);

        // Reset during write ACCESS: write commits, no ack follows
        a0 = ack0_cnt; a1 = ack1_cnt;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0001; bus.wdata0 = 8'h77;
        tick();
        check_eq("rstacc_load", bus.mem_load_main, 1);
        bus.req0 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstacc_mem", mem[16'h0001], 8'h77);
        check_reset_vals("rstacc");
        tick();
        tick();
        check_eq("rstacc_noack0", ack0_cnt - a0, 0);
        check_eq("rstacc_noack1", ack1_cnt - a1, 0);

        // Single-cycle req0 pulse yields exactly one access
        a0 = ack0_cnt; a1 = ack1_cnt; wr0 = wr_cnt;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
        tick();
        bus.req0 = 1'b0;
        repeat (8) tick();
        check_eq("pulse_ack0", ack0_cnt - a0, 1);
        check_eq("pulse_ack1", ack1_cnt - a1, 0);
        check_eq("pulse_nowr", wr_cnt - wr0, 0);
        check_eq("pulse_rd0", bus.rdata0, 8'h55);
        check_eq("pulse_idle", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH_ADDR, default 16, memory address width.
REQ-002 Parameter WIDTH, default 8, memory data width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0, req1  input  1 each  access request from port 0 (CPU) / port 1 (loader).
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; sampled with req.
REQ-007 addr0, addr1  input  WIDTH_ADDR each  request address.
REQ-008 wdata0, wdata1  input  WIDTH each  write data.
REQ-009 ack0, ack1  output  1 each  one-cycle completion pulse per port.
REQ-010 rdata0, rdata1  output  WIDTH each  per-port read result register.
REQ-011 mem_addr  output  WIDTH_ADDR  address to memory.
REQ-012 mem_bus_dir  output  1  0 = main->mem (write), 1 = mem->main (read).
REQ-013 mem_load_main  output  1  memory write strobe, committed at rising clk.
REQ-014 mem_wdata  output  WIDTH  write data to memory.
REQ-015 mem_rdata  input  WIDTH  asynchronous read data from memory at mem_addr.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, DONE; IDLE->ACCESS when req0|req1, ACCESS->DONE always, DONE->IDLE always.
REQ-018 In IDLE with a request, the block SHALL latch winner, we, addr, wdata of the winner at the edge entering ACCESS.
REQ-019 Arbitration SHALL be round-robin: a sole requester wins; on a tie, the port not granted last wins; after reset, port 0 wins the first tie.
REQ-020 In ACCESS, mem_addr SHALL equal the latched address, mem_bus_dir = !we_q, mem_load_main = we_q, mem_wdata = wdata_q.
REQ-021 mem_load_main SHALL be high only in ACCESS with we_q=1, so that each write commits exactly once.
REQ-022 For reads, rdata of the winner SHALL capture mem_rdata at the edge leaving ACCESS; the other port's rdata SHALL be unchanged.
REQ-023 In DONE, ack of the winner SHALL be 1 for exactly one cycle; the other ack SHALL be 0.
REQ-024 Latency: request seen in IDLE at cycle N -> ACCESS at N+1 -> ack and valid rdata at N+2; peak throughput is one access per 3 cycles.
REQ-025 req SHALL NOT be sampled in ACCESS or DONE; a requester holding req through ack gets a second access only if req is still high in the following IDLE cycle.
REQ-026 Changes to addr/we/wdata after latching SHALL NOT affect the transaction in flight.
REQ-027 rdata SHALL hold its value until the next read completes for that port.
REQ-028 Outside ACCESS: mem_bus_dir = 1, mem_load_main = 0, and mem_addr holds its last value.

Reset
REQ-029 With rst=1 at an edge, the block SHALL enter IDLE and clear ack0/1=0, rdata0/1=0, mem_addr=0, mem_wdata=0, and busy=0, and SHALL set last_grant so that port 0 wins the next tie.
REQ-030 rst during ACCESS SHALL NOT suppress the write strobe for that edge (mem_load_main derives from state), and no ack SHALL follow.
REQ-031 rst during DONE SHALL clear ack at that edge.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, DONE), the port-count constant (2), and the reset values.
REQ-033 Round-robin selection SHALL live in sub-module rr_arbiter2 (inputs req[1:0], last_grant; output grant index); all else SHALL be in mem_arbiter.

Verification
REQ-034 Write 8'hA5 to 16'h1234 via port 0, then read it back via port 1 -> the write strobe pulses once with mem_addr=16'h1234, and rdata1=8'hA5 at ack1.
REQ-035 Both ports request in the same cycle after reset, held continuously -> grants alternate 0,1,0,1, with acks spaced 3 cycles apart.
REQ-036 Port 0 changes addr0 from 16'h0010 to 16'h0020 during ACCESS -> the access uses 16'h0010.
REQ-037 Port 1 reads 16'hFFFF (preloaded 8'h3C) while port 0 idle -> ack1 at N+2, rdata1=8'h3C, and rdata0 is unchanged.
REQ-038 rst asserted during a write ACCESS to 16'h0001 -> the memory word is updated, no ack occurs, and all outputs match their reset values on the next cycle.
REQ-039 Single req0 pulse of one IDLE cycle -> exactly one access and one ack0, with no repeat.
